// File: rtl/sevenseg_scroller.sv
// Message source for a 4-digit seven-segment driver. It stores an ASCII message written over
// a valid/ready port, then shows it static (<=4 chars, left-justified) or scrolls it right-to-left.
module sevenseg_scroller #(
   parameter int MSG_DEPTH = 16,
   parameter int TICK_DIV  = 12_500_000
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             clear,
   input  logic                             wr_valid,
   input  logic [7:0]                       wr_data,
   input  logic                             wr_last,
   output logic                             wr_ready,
   output logic [7:0]                       display_0,
   output logic [7:0]                       display_1,
   output logic [7:0]                       display_2,
   output logic [7:0]                       display_3,
   output logic [1:0]                       decplace,
   output logic [$clog2(MSG_DEPTH+1)-1:0]   msg_len,
   output logic                             scrolling
);

   localparam int AW = $clog2(MSG_DEPTH + 1);
   localparam int BW = $clog2(MSG_DEPTH);
   localparam int PW = $clog2(MSG_DEPTH + 4) + 1;
   localparam int TW = $clog2(TICK_DIV);
   localparam logic [7:0] SPACE = 8'h20;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STATIC, ST_SCROLL} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [AW-1:0]   r_count;
   logic [AW-1:0]   r_msg_len;
   logic [PW-1:0]   r_pos;
   logic [TW-1:0]   r_tick_cnt;
   logic [7:0]      r_buf [MSG_DEPTH];

   logic            w_hs;
   logic            w_commit;
   logic            w_tick;
   logic [AW-1:0]   w_new_count;
   logic [BW-1:0]   w_wr_idx;
   logic [PW-1:0]   w_period;

   assign wr_ready  = (r_state != ST_LOAD) | (r_count < AW'(MSG_DEPTH));
   assign w_hs      = wr_valid & wr_ready;
   assign w_tick    = (r_state == ST_SCROLL) && (r_tick_cnt == TW'(TICK_DIV - 1));
   assign w_period  = PW'(r_msg_len) + PW'(4);
   assign decplace  = 2'b00;
   assign msg_len   = r_msg_len;
   assign scrolling = (r_state == ST_SCROLL);

   // NOTE: every signal driven here gets a value on every path, so no latch can be inferred.
   always_comb begin
      w_new_count = (r_state == ST_LOAD) ? r_count + AW'(1) : AW'(1);
      w_wr_idx    = (r_state == ST_LOAD) ? r_count[BW-1:0] : '0;
      w_commit    = w_hs & (wr_last | (w_new_count == AW'(MSG_DEPTH)));
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = ST_IDLE;
      end else if (w_hs) begin
         if (!w_commit)                    w_state_nxt = ST_LOAD;
         else if (w_new_count <= AW'(4))   w_state_nxt = ST_STATIC;
         else                              w_state_nxt = ST_SCROLL;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rstn || clear) begin
         r_count    <= '0;
         r_msg_len  <= '0;
         r_pos      <= '0;
         r_tick_cnt <= '0;
      end else if (w_hs) begin
         r_count   <= w_new_count;
         r_msg_len <= w_commit ? w_new_count : '0;
         if (w_commit) begin
            r_pos      <= '0;
            r_tick_cnt <= '0;
         end
      end else if (r_state == ST_SCROLL) begin
         r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
         if (w_tick) r_pos <= (r_pos == w_period - PW'(1)) ? '0 : r_pos + PW'(1);
      end
   end

   // NOTE: the message buffer is not reset; only chars below msg_len are ever shown.
   always_ff @(posedge clk) begin
      if (rstn && !clear && w_hs) r_buf[w_wr_idx] <= wr_data;
   end

   // Digit k shows S[(pos+k) mod P]; raw < 2P, so a single conditional subtract wraps it.
   for (genvar k = 0; k < 4; k++) begin : g_disp
      logic [PW-1:0] w_raw;
      logic [PW-1:0] w_sidx;
      logic [7:0]    w_char;
      logic [7:0]    r_char;

      assign w_raw  = r_pos + PW'(k);
      assign w_sidx = (w_raw >= w_period) ? w_raw - w_period : w_raw;

      always_comb begin
         w_char = SPACE;
         case (r_state)
            ST_STATIC: if (AW'(k) < r_msg_len)        w_char = r_buf[k];
            ST_SCROLL: if (w_sidx < PW'(r_msg_len))   w_char = r_buf[w_sidx[BW-1:0]];
            default:   w_char = SPACE;
         endcase
      end

      always_ff @(posedge clk) begin
         if (!rstn) r_char <= SPACE;
         else       r_char <= w_char;
      end
   end

   assign display_0 = g_disp[0].r_char;
   assign display_1 = g_disp[1].r_char;
   assign display_2 = g_disp[2].r_char;
   assign display_3 = g_disp[3].r_char;

endmodule

// File: tb/tb_sevenseg_scroller.sv
// Directed bench for sevenseg_scroller: reset, static, scroll, overwrite, full-buffer commit
// and clear-vs-write collision, all against hand-computed display values.
module tb_sevenseg_scroller;

   localparam int MSG_DEPTH = 16;
   localparam int TICK_DIV  = 4;
   localparam int AW        = $clog2(MSG_DEPTH + 1);

   logic          clk = 1'b0;
   logic          rstn;
   logic          clear;
   logic          wr_valid;
   logic [7:0]    wr_data;
   logic          wr_last;
   logic          wr_ready;
   logic [7:0]    display_0, display_1, display_2, display_3;
   logic [1:0]    decplace;
   logic [AW-1:0] msg_len;
   logic          scrolling;

   int n_checks = 0;
   int n_fail   = 0;

   sevenseg_scroller #(.MSG_DEPTH(MSG_DEPTH), .TICK_DIV(TICK_DIV)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .clear     (clear),
      .wr_valid  (wr_valid),
      .wr_data   (wr_data),
      .wr_last   (wr_last),
      .wr_ready  (wr_ready),
      .display_0 (display_0),
      .display_1 (display_1),
      .display_2 (display_2),
      .display_3 (display_3),
      .decplace  (decplace),
      .msg_len   (msg_len),
      .scrolling (scrolling)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_disp(input string tag, input logic [31:0] exp);
      check(tag, {display_0, display_1, display_2, display_3}, exp);
   endtask

   // Called at a negedge; the handshake happens on the following posedge.
   task automatic write_byte(input logic [7:0] d, input logic last);
      wr_valid = 1'b1;
      wr_data  = d;
      wr_last  = last;
      #1;
      check("wr_ready_on_write", {31'd0, wr_ready}, 32'd1);
      @(negedge clk);
      wr_valid = 1'b0;
      wr_last  = 1'b0;
   endtask

   logic [7:0] hello_s [9];

   initial begin
      hello_s = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h20, 8'h20, 8'h20};
      rstn = 1'b0; clear = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; wr_last = 1'b0;

      // Reset
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      check_disp("reset_disp", 32'h20202020);
      check("reset_wr_ready", {31'd0, wr_ready}, 32'd1);
      check("reset_msg_len", 32'(msg_len), 32'd0);
      check("reset_scrolling", {31'd0, scrolling}, 32'd0);
      check("decplace", {30'd0, decplace}, 32'd0);

      // Static "HI"
      write_byte(8'h48, 1'b0);
      check("load_msg_len", 32'(msg_len), 32'd0);
      write_byte(8'h49, 1'b1);
      check("hi_commit_len", 32'(msg_len), 32'd2);
      check_disp("hi_disp_pipeline", 32'h20202020);
      @(negedge clk);
      check_disp("hi_disp", 32'h48492020);
      check("hi_scrolling", {31'd0, scrolling}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         repeat (100) @(negedge clk);
         check_disp("hi_hold", 32'h48492020);
      end

      // Scroll "HELLO": P = 9, one step every TICK_DIV cycles, wraps back to start
      write_byte(8'h48, 1'b0);
      write_byte(8'h45, 1'b0);
      write_byte(8'h4C, 1'b0);
      write_byte(8'h4C, 1'b0);
      check_disp("hello_load_blank", 32'h20202020);
      write_byte(8'h4F, 1'b1);
      check("hello_len", 32'(msg_len), 32'd5);
      check("hello_scrolling", {31'd0, scrolling}, 32'd1);
      @(negedge clk);
      for (int p = 0; p <= 9; p++) begin
         for (int j = 0; j < TICK_DIV; j++) begin
            check_disp($sformatf("hello_pos%0d_c%0d", p, j),
                       {hello_s[p % 9], hello_s[(p + 1) % 9], hello_s[(p + 2) % 9], hello_s[(p + 3) % 9]});
            @(negedge clk);
         end
      end

      // Overwrite during scroll with single char
      repeat (2) @(negedge clk);
      write_byte(8'h41, 1'b1);
      check("ovr_len", 32'(msg_len), 32'd1);
      check("ovr_scrolling", {31'd0, scrolling}, 32'd0);
      @(negedge clk);
      check_disp("ovr_disp", 32'h41202020);

      // Full buffer: 16 chars, no wr_last -> implicit commit
      for (int i = 0; i < MSG_DEPTH - 1; i++) write_byte(8'(8'h61 + i), 1'b0);
      check("full_pre_len", 32'(msg_len), 32'd0);
      check("full_pre_scrolling", {31'd0, scrolling}, 32'd0);
      write_byte(8'h70, 1'b0);
      check("full_len", 32'(msg_len), 32'd16);
      check("full_scrolling", {31'd0, scrolling}, 32'd1);
      @(negedge clk);
      check_disp("full_disp0", 32'h61626364);
      repeat (TICK_DIV) @(negedge clk);
      check_disp("full_disp1", 32'h62636465);

      // Clear colliding with a handshake: byte dropped
      clear    = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 8'h5A;
      wr_last  = 1'b1;
      @(negedge clk);
      clear = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
      check("clr_len", 32'(msg_len), 32'd0);
      check("clr_scrolling", {31'd0, scrolling}, 32'd0);
      check("clr_wr_ready", {31'd0, wr_ready}, 32'd1);
      @(negedge clk);
      check_disp("clr_disp", 32'h20202020);
      repeat (8) @(negedge clk);
      check_disp("clr_disp_hold", 32'h20202020);
      check("clr_len_hold", 32'(msg_len), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
